// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU load/store path
// and a DMA/debug loader. The grant is combinational with zero latency, so a
// single-cycle load completes in its own cycle. When both sides request, the
// grant goes round-robin. The DMA side can lock memory for a burst of up to
// MAX_BURST consecutive beats.
//
// Optional build macro ARB_PERF_CNT_EN: adds the stall_cnt output. It is a
// saturating count of the cycles in which the CPU was stalled.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  ARB   | per-cycle arbitration; round-robin on conflict via last_win
//  LOCK  | DMA holds memory for its burst; beat_cnt counts granted beats
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wd,
    input  logic [1:0]    cpu_size,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wd,
    input  logic [1:0]    dma_size,
    output logic          dma_gnt,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    output logic [1:0]    mem_size,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]   stall_cnt,
`endif
    input  logic [DW-1:0] mem_rd
);

    localparam int BW = $clog2(MAX_BURST + 1);
    // With MAX_BURST=1 a locked beat can never extend, so LOCK is unreachable.
    localparam logic LOCK_EN = (MAX_BURST > 1);
    // beat_cnt value that marks the final beat a burst may take.
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          last_win, last_win_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;

    // State register: reset gives the CPU the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            last_win <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_win <= last_win_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Grant decision and next-state logic.
    always_comb begin
        cpu_gnt      = 1'b0;
        dma_gnt      = 1'b0;
        state_nxt    = state;
        last_win_nxt = last_win;
        beat_cnt_nxt = beat_cnt;
        case (state)
            ARB: begin
                if (cpu_req && dma_req) begin
                    if (last_win) cpu_gnt = 1'b1;
                    else          dma_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (dma_req) begin
                    dma_gnt = 1'b1;
                end
                if (dma_gnt && dma_lock && LOCK_EN) begin
                    state_nxt    = LOCK;
                    beat_cnt_nxt = BW'(1);
                end
            end
            LOCK: begin
                if (dma_req) begin
                    dma_gnt      = 1'b1;
                    beat_cnt_nxt = beat_cnt + BW'(1);
                    if (!dma_lock || beat_cnt == LAST_BEAT) begin
                        state_nxt    = ARB;
                        beat_cnt_nxt = '0;
                    end
                end else begin
                    // The DMA has let go: a waiting CPU is granted in this same cycle.
                    cpu_gnt      = cpu_req;
                    state_nxt    = ARB;
                    beat_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ARB;
                beat_cnt_nxt = '0;
            end
        endcase
        // A DMA grant sets last_win=1. When the burst limit forces a release,
        // this lets a pending CPU win the next cycle.
        if (cpu_gnt) last_win_nxt = 1'b0;
        if (dma_gnt) last_win_nxt = 1'b1;
    end

    // Memory-port mux: the DMA fields when the DMA owns the port, else the CPU fields.
    always_comb begin
        cpu_stall = cpu_req & ~cpu_gnt;
        rdata     = mem_rd;
        if (dma_gnt) begin
            mem_addr = dma_addr;
            mem_wd   = dma_wd;
            mem_size = dma_size;
        end else begin
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
            mem_size = cpu_size;
        end
        mem_we = ((cpu_gnt & cpu_we) | (dma_gnt & dma_we)) & ~rst;
    end

`ifdef ARB_PERF_CNT_EN
    // Saturating count of the cycles in which the CPU was stalled.
    always_ff @(posedge clk) begin
        if (rst)                                  stall_cnt <= '0;
        else if (cpu_stall && stall_cnt != '1)    stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It runs directed scenarios first, then
// randomized traffic. Every cycle is compared against a rule-level model
// of who owns memory.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd;
    logic [1:0]    cpu_size;
    logic          cpu_gnt, cpu_stall;
    logic          dma_req, dma_lock, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wd;
    logic [1:0]    dma_size;
    logic          dma_gnt;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic [DW-1:0] mem_rd;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_size(cpu_size), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wd(dma_wd), .dma_size(dma_size), .dma_gnt(dma_gnt),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_size(mem_size),
`ifdef ARB_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model, described at the level of ownership rules.
    bit          m_burst;      // DMA currently holds memory for a burst
    int          m_beats;      // beats the DMA has taken in this burst
    bit          m_cpu_first;  // the CPU wins the next conflict
    bit          e_cpu, e_dma;
    logic [31:0] m_stalls;

    task automatic model_reset();
        m_burst = 0; m_beats = 0; m_cpu_first = 1; m_stalls = 0;
    endtask

    task automatic model_grant();
        e_cpu = 0; e_dma = 0;
        if (m_burst) begin
            if (dma_req) e_dma = 1;
            else         e_cpu = cpu_req;
        end else if (cpu_req && dma_req) begin
            e_cpu = m_cpu_first;
            e_dma = !m_cpu_first;
        end else begin
            e_cpu = cpu_req;
            e_dma = dma_req;
        end
    endtask

    task automatic model_commit();
        int beats;
        if (rst) begin
            model_reset();
            return;
        end
        if (cpu_req && !e_cpu && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        if (e_cpu) m_cpu_first = 0;
        if (e_dma) m_cpu_first = 1;
        if (e_dma) begin
            beats = m_burst ? m_beats + 1 : 1;
            if (dma_lock && beats < MAX_BURST) begin
                m_burst = 1; m_beats = beats;
            end else begin
                m_burst = 0; m_beats = 0;
            end
        end else begin
            m_burst = 0; m_beats = 0;
        end
    endtask

    // exp_owner: -1 means don't care, 0 means no grant, 1 means CPU, 2 means DMA.
    task automatic settle(input int exp_owner);
        #3;
        model_grant();
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
        chk("dma_gnt", 32'(dma_gnt), 32'(e_dma));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cpu));
        chk("mem_we", 32'(mem_we), 32'(!rst && ((e_cpu && cpu_we) || (e_dma && dma_we))));
        chk("mem_addr", mem_addr, e_dma ? dma_addr : cpu_addr);
        chk("mem_wd", mem_wd, e_dma ? dma_wd : cpu_wd);
        chk("mem_size", 32'(mem_size), 32'(e_dma ? dma_size : cpu_size));
        chk("rdata", rdata, mem_rd);
`ifdef ARB_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stalls);
`endif
        if (exp_owner >= 0)
            chk("owner", {30'b0, dma_gnt, cpu_gnt},
                (exp_owner == 1) ? 32'd1 : (exp_owner == 2) ? 32'd2 : 32'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic cyc(input int exp_owner);
        settle(exp_owner);
        advance();
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wd = '0; cpu_size = 2'd2;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wd = '0; dma_size = 2'd2;
        mem_rd = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        advance();
        rst = 0;
    endtask

    bit cpu_pend, dma_pend;

    initial begin
        idle_inputs();
        model_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;

        // 1: after reset, a CPU load is granted and read data returns in the same cycle.
        settle(0);
        advance();
        cpu_req = 1; cpu_addr = 32'h10; mem_rd = 32'hDEAD_BEEF;
        settle(1);
        chk("t1_stall", 32'(cpu_stall), 32'd0);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        advance();

        // 2: two requesters without lock share the port round-robin, starting with the CPU.
        do_reset();
        cpu_req = 1; dma_req = 1; dma_addr = 32'h80;
        for (int i = 0; i < 4; i++) begin
            settle((i % 2 == 0) ? 1 : 2);
            chk("t2_stall", 32'(cpu_stall), (i % 2 == 1) ? 32'd1 : 32'd0);
            advance();
        end

        // 3: a locked DMA burst is capped at MAX_BURST beats, then the CPU gets one turn.
        do_reset();
        idle_inputs();
        cpu_req = 1;
        cyc(1);
        dma_req = 1; dma_lock = 1;
        for (int i = 0; i < MAX_BURST; i++) cyc(2);
        cyc(1);
        cyc(2);

        // 4: the DMA drops its request during a burst; the pending CPU is granted in that same cycle.
        do_reset();
        idle_inputs();
        cpu_req = 1;
        cyc(1);
        dma_req = 1; dma_lock = 1;
        for (int i = 0; i < 3; i++) cyc(2);
        dma_req = 0;
        cyc(1);
        chk("t4_fsm_arb", 32'(dut.state), 32'd0);

        // 5: a DMA write wins over a stalled CPU write; a reset during the burst suppresses the write.
        do_reset();
        idle_inputs();
        cpu_req = 1;
        cyc(1);
        cpu_we = 1; cpu_addr = 32'h40; cpu_wd = 32'h99;
        dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 32'h20; dma_wd = 32'h55;
        settle(2);
        chk("t5_we", 32'(mem_we), 32'd1);
        chk("t5_addr", mem_addr, 32'h20);
        chk("t5_wd", mem_wd, 32'h55);
        chk("t5_stall", 32'(cpu_stall), 32'd1);
        advance();
        rst = 1;
        settle(-1);
        chk("t5_rst_we", 32'(mem_we), 32'd0);
        advance();
        rst = 0;
        chk("t5_fsm_arb", 32'(dut.state), 32'd0);
        cyc(1);

        // Randomized traffic; a requester keeps its fields stable while it is pending.
        idle_inputs();
        do_reset();
        cpu_pend = 0; dma_pend = 0;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            if (!cpu_pend) begin
                cpu_req = ($urandom_range(0, 99) < 60);
                cpu_we = $urandom_range(0, 1);
                cpu_addr = $urandom; cpu_wd = $urandom; cpu_size = 2'($urandom_range(0, 3));
            end
            if (!dma_pend) begin
                dma_req = ($urandom_range(0, 99) < 60);
                dma_we = $urandom_range(0, 1);
                dma_addr = $urandom; dma_wd = $urandom; dma_size = 2'($urandom_range(0, 3));
            end
            dma_lock = ($urandom_range(0, 99) < 70);
            mem_rd = $urandom;
            settle(-1);
            cpu_pend = cpu_req && !e_cpu && !rst;
            dma_pend = dma_req && !e_dma && !rst;
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
